mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with EX/MEM and MEM/WB registers, handshaked data memory and access timeout.
// Optional subword loads/stores are enabled by defining MEM_SUBWORD_EN.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic [2:0]  funct3_ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        stall_mem,
  output logic        err_mem
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [31:0] wd_r, load_data;
  logic mr_r, mw_r, timeout;
`ifdef MEM_SUBWORD_EN
  logic [2:0] f3_r;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
`else
  logic unused_f3;
  assign unused_f3 = ^funct3_ex;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult_mem <= '0;
      wd_r <= '0;
      rdAddr_mem <= '0;
      RegWrite_mem <= 1'b0;
      mr_r <= 1'b0;
      mw_r <= 1'b0;
`ifdef MEM_SUBWORD_EN
      f3_r <= '0;
`endif
    end else if (!stall_mem) begin
      ALUResult_mem <= ALUResult_ex;
      wd_r <= MemWriteData_ex;
      rdAddr_mem <= rdAddr_ex;
      RegWrite_mem <= RegWrite_ex;
      mr_r <= MemRead_ex;
      mw_r <= MemWrite_ex;
`ifdef MEM_SUBWORD_EN
      f3_r <= funct3_ex;
`endif
    end
  end
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_n;
    cnt <= (reset || state == IDLE) ? 4'd0 : cnt + 4'd1;
  end
  always_comb begin
    dmem_req = state == WAIT || mr_r || mw_r;
    timeout = state == WAIT && cnt == 4'hF && !dmem_ack;
    stall_mem = dmem_req && !dmem_ack && !timeout;
    state_n = state == IDLE ? ((dmem_req && !dmem_ack) ? WAIT : IDLE)
                            : ((dmem_ack || timeout) ? IDLE : WAIT);
  end
  assign err_mem = timeout;
  assign dmem_we = mw_r;
  assign dmem_addr = {ALUResult_mem[31:2], 2'b00};
`ifdef MEM_SUBWORD_EN
  always_comb begin
    byte_sel = dmem_rdata[{ALUResult_mem[1:0], 3'b000} +: 8];
    half_sel = ALUResult_mem[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = f3_r == 3'b000 ? {{24{byte_sel[7]}}, byte_sel} :
                f3_r == 3'b100 ? {24'd0, byte_sel} :
                f3_r == 3'b001 ? {{16{half_sel[15]}}, half_sel} :
                f3_r == 3'b101 ? {16'd0, half_sel} : dmem_rdata;
    dmem_be = f3_r[1:0] == 2'b00 ? 4'b0001 << ALUResult_mem[1:0] :
              f3_r[1:0] == 2'b01 ? (ALUResult_mem[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    dmem_wdata = f3_r[1:0] == 2'b00 ? {4{wd_r[7:0]}} :
                 f3_r[1:0] == 2'b01 ? {2{wd_r[15:0]}} : wd_r;
  end
`else
  assign load_data = dmem_rdata;
  assign dmem_be = 4'b1111;
  assign dmem_wdata = wd_r;
`endif
  // stalled or timed-out cycles retire a bubble; data and rd are held
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteData_wb <= '0;
      rdAddr_wb <= '0;
      RegWrite_wb <= 1'b0;
    end else if (stall_mem || timeout) begin
      RegWrite_wb <= 1'b0;
    end else begin
      RegWriteData_wb <= mr_r ? load_data : ALUResult_mem;
      rdAddr_wb <= rdAddr_mem;
      RegWrite_wb <= RegWrite_mem;
    end
  end
endmodule
